mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares one downstream request/ack memory port between `NUM_REQ` upstream requesters. Each upstream port speaks the same mreq/mack protocol the APB bridge emits, so the APB bridge and internal masters (e.g. UART DMA or config sequencer) can reach one register/memory target. One transaction is outstanding at a time. An optional watchdog completes stalled transactions with an error response.

## Interface
- `NUM_REQ`, 2: number of upstream requesters (≥2)
- `ADDR_WIDTH`, 32: address width
- `DATA_WIDTH`, 32: data width
- `STRB_WIDTH`, `DATA_WIDTH/8`: byte-strobe width
- `MRESP_WIDTH`, 1: response width; bit 0 = error
- `TIMEOUT_CYCLES`, 0: watchdog limit in cycles; 0 disables it

- `clk_i`  in  1  clock, rising edge
- `arst_ni`  in  1  reset, asynchronous, active-low
- `req_i`  in  `NUM_REQ`  per-requester request, held until its ack
- `req_addr_i`  in  `NUM_REQ`×`ADDR_WIDTH`  per-requester address
- `req_we_i`  in  `NUM_REQ`  per-requester write enable
- `req_wdata_i`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester write data
- `req_strb_i`  in  `NUM_REQ`×`STRB_WIDTH`  per-requester strobes
- `req_ack_o`  out  `NUM_REQ`  one-cycle ack pulse to the granted requester
- `req_rdata_o`  out  `DATA_WIDTH`  read data, shared, valid with ack
- `req_resp_o`  out  `MRESP_WIDTH`  response, shared, valid with ack
- `mreq_o`  out  1  downstream request
- `maddr_o`, `mwe_o`, `mwdata_o`, `mstrb_o`  out  as above  downstream payload, muxed from the granted requester
- `mack_i`  in  1  downstream ack pulse
- `mrdata_i`  in  `DATA_WIDTH`  downstream read data
- `mresp_i`  in  `MRESP_WIDTH`  downstream response
- `grant_o`  out  `NUM_REQ`  one-hot current grant; 0 when idle
- `busy_o`  out  1  a transaction is in flight
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states are IDLE and BUSY.
- **Reset:** state IDLE; `grant_o`=0; `mreq_o`=0; `busy_o`=0; `timeout_o`=0; `req_ack_o`=0; priority pointer=0; watchdog count=0.
- **IDLE:**
  - If any `req_i` bit is set, pick the first set bit at or after the pointer, wrapping modulo `NUM_REQ`.
  - Register the pick into `grant_o` and move to BUSY.
  - If no bit is set, stay in IDLE.
- **BUSY:**
  - `mreq_o`=1 and `busy_o`=1.
  - Payload outputs are combinationally muxed from `grant_o`. Requesters hold their payload stable while `req_i` is high.
- **Normal completion:** when `mack_i`=1 in BUSY:
  - `req_ack_o[g]`=1 that same cycle; `req_rdata_o`/`req_resp_o` pass through `mrdata_i`/`mresp_i` combinationally.
  - Next state IDLE; pointer becomes (g+1) mod `NUM_REQ`; grant clears.
- **Watchdog (`TIMEOUT_CYCLES`>0):**
  - The counter clears on entry to BUSY and increments each BUSY cycle without `mack_i`.
  - When the count reaches `TIMEOUT_CYCLES`-1 with no ack: `req_ack_o[g]`=1; `req_resp_o` has bit 0=1 and other bits 0; `req_rdata_o`=0; `timeout_o`=1; go to IDLE; the pointer advances as for normal completion.
  - If `mack_i` arrives in the same cycle the watchdog would fire, `mack_i` wins: normal completion, no timeout.
- **Stray acks:** `mack_i` while IDLE is ignored. `req_ack_o` stays 0 and no state changes.
- **Outside an ack cycle:** `req_rdata_o` and `req_resp_o` are 0.
- A requester that drops `req_i` before its ack is a protocol violation; behaviour is undefined and the bench flags it.

## Timing
- `req_i` rising at cycle 0 with the arbiter idle gives `grant_o`/`mreq_o`=1 at cycle 1.
- Ack at cycle k gives `mreq_o`=0 at k+1. The earliest next `mreq_o` is k+2, which is one mandatory IDLE cycle.
- Ack latency to the requester is 0 cycles from `mack_i`.
- With a pending `req_i`, a watchdog abort occurs after exactly `TIMEOUT_CYCLES` BUSY cycles.
- Asserting `arst_ni` mid-transaction drops `mreq_o` and all acks immediately. The downstream must abandon the transaction.

## Structure
- `mem_arbiter_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY`) and the error-response constant (bit 0 set).
- Sub-module `rr_pick`: combinational round-robin first-set-bit search from the pointer with wrap. Outputs are a one-hot grant and its index. Parameterised by `NUM_REQ`.
- The top level holds the FSM, grant, pointer, watchdog counter and payload muxes.

## Test plan
- **Single requester:** `NUM_REQ`=2, `req_i`=01 with addr 0x10, write, wdata 0xA5A5A5A5. `mack_i` at cycle 3 → `mreq_o` high cycles 1-3; `maddr_o`=0x10; `req_ack_o`=01 at cycle 3; `mreq_o`=0 at cycle 4.
- **Fairness:** both requesters held continuously → grants alternate 01, 10, 01, 10, with exactly one IDLE cycle between transactions.
- **Read return:** requester 1 reads, downstream returns `mrdata_i`=0xDEADBEEF and `mresp_i`=0 → `req_rdata_o`=0xDEADBEEF with `req_ack_o`=10, same cycle.
- **Timeout:** `TIMEOUT_CYCLES`=4, no `mack_i` → `req_ack_o` and `timeout_o` pulse on the 4th BUSY cycle, `req_resp_o`=1, `req_rdata_o`=0. A late `mack_i` afterwards is ignored. Also check the tie case: `mack_i` on the 4th cycle gives normal completion with `timeout_o`=0.
- **Reset mid-op:** pull `arst_ni` low while BUSY with requester 1 → `mreq_o`/`grant_o`/`busy_o` go to 0 asynchronously. After release, with both requesting, requester 0 is granted first (pointer=0).
- **Wrap, `NUM_REQ`=4:** pointer=3 after serving requester 2, `req_i`=0101 → requester 0 is granted next, then requester 2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the round-robin memory-port arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: idle, or one transaction outstanding downstream.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Response returned to a requester whose transaction the watchdog aborts.
    // Only bit 0 (error) is set; it is resized to the response width at use.
    localparam int MRESP_ERR = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin search: the first set request bit at or after
// the priority pointer, wrapping modulo NUM_REQ. Gives one-hot and index.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Walk the candidates in priority order starting at the pointer.
    always_comb begin
        int                cand;
        logic [IDX_W-1:0]  cand_idx;
        logic              found;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                valid_o           = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream mreq/mack port between NUM_REQ
// upstream requesters. One transaction outstanding at a time; an optional
// watchdog completes a stalled transaction with an error response.
//
// Handshake: a requester raises req_i with a stable payload and holds both
// until it sees its one-cycle req_ack_o pulse. Downstream, mreq_o stays high
// with a stable payload until the one-cycle mack_i pulse; read data and
// response are forwarded to the requester in that same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MRESP_WIDTH    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic [DATA_WIDTH-1:0]         req_rdata_o,
    output logic [MRESP_WIDTH-1:0]        req_resp_o,
    output logic                          mreq_o,
    output logic [ADDR_WIDTH-1:0]         maddr_o,
    output logic                          mwe_o,
    output logic [DATA_WIDTH-1:0]         mwdata_o,
    output logic [STRB_WIDTH-1:0]         mstrb_o,
    input  logic                          mack_i,
    input  logic [DATA_WIDTH-1:0]         mrdata_i,
    input  logic [MRESP_WIDTH-1:0]        mresp_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o,
    output logic                          dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State, grant, pointer and watchdog registers; reset drops everything.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Next-state logic plus the ack/response path; mack_i beats the watchdog.
    always_comb begin
        logic done;
        done        = 1'b0;
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        wd_cnt_d    = wd_cnt_q;
        req_ack_o   = '0;
        req_rdata_o = '0;
        req_resp_o  = '0;
        timeout_o   = 1'b0;
        mreq_o      = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_BUSY;
                    grant_d  = pick_grant;
                    gidx_d   = pick_idx;
                    wd_cnt_d = '0;
                end
            end
            ARB_BUSY: begin
                mreq_o = 1'b1;
                busy_o = 1'b1;
                if (mack_i) begin
                    done        = 1'b1;
                    req_ack_o   = grant_q;
                    req_rdata_o = mrdata_i;
                    req_resp_o  = mresp_i;
                end else if ((TIMEOUT_CYCLES > 0) && (wd_cnt_q == WD_LAST)) begin
                    done       = 1'b1;
                    req_ack_o  = grant_q;
                    req_resp_o = MRESP_WIDTH'(MRESP_ERR);
                    timeout_o  = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == LAST_IDX) ? '0 : (gidx_q + 1'b1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Downstream payload: AND-OR mux on the one-hot grant, zero when idle.
    always_comb begin
        maddr_o  = '0;
        mwe_o    = 1'b0;
        mwdata_o = '0;
        mstrb_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                maddr_o  = maddr_o  | req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mwe_o    = mwe_o    | req_we_i[i];
                mwdata_o = mwdata_o | req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                mstrb_o  = mstrb_o  | req_strb_i[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign grant_o     = grant_q;
    assign dbg_state_o = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port instance with a 4-cycle watchdog
// and a 4-port instance without watchdog for the pointer wrap case.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- 2-port DUT (TIMEOUT_CYCLES=4) ----------------
    logic [1:0]  a_req = '0;
    logic [63:0] a_addr = '0;
    logic [1:0]  a_we = '0;
    logic [63:0] a_wdata = '0;
    logic [7:0]  a_strb = '0;
    logic [1:0]  a_ack;
    logic [31:0] a_rdata;
    logic [0:0]  a_resp;
    logic        a_mreq;
    logic [31:0] a_maddr;
    logic        a_mwe;
    logic [31:0] a_mwdata;
    logic [3:0]  a_mstrb;
    logic        a_mack = 1'b0;
    logic [31:0] a_mrdata = '0;
    logic [0:0]  a_mresp = '0;
    logic [1:0]  a_grant;
    logic        a_busy;
    logic        a_timeout;
    logic        a_dbg;

    mem_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
        .MRESP_WIDTH(1), .TIMEOUT_CYCLES(4)
    ) dut_a (
        .clk_i(clk), .arst_ni(arst_n),
        .req_i(a_req), .req_addr_i(a_addr), .req_we_i(a_we),
        .req_wdata_i(a_wdata), .req_strb_i(a_strb),
        .req_ack_o(a_ack), .req_rdata_o(a_rdata), .req_resp_o(a_resp),
        .mreq_o(a_mreq), .maddr_o(a_maddr), .mwe_o(a_mwe),
        .mwdata_o(a_mwdata), .mstrb_o(a_mstrb),
        .mack_i(a_mack), .mrdata_i(a_mrdata), .mresp_i(a_mresp),
        .grant_o(a_grant), .busy_o(a_busy), .timeout_o(a_timeout),
        .dbg_state_o(a_dbg)
    );

    // ---------------- 4-port DUT (watchdog off) ----------------
    logic [3:0]   b_req = '0;
    logic [127:0] b_addr = '0;
    logic [3:0]   b_we = '0;
    logic [127:0] b_wdata = '0;
    logic [15:0]  b_strb = '0;
    logic [3:0]   b_ack;
    logic [31:0]  b_rdata;
    logic [0:0]   b_resp;
    logic         b_mreq;
    logic [31:0]  b_maddr;
    logic         b_mwe;
    logic [31:0]  b_mwdata;
    logic [3:0]   b_mstrb;
    logic         b_mack = 1'b0;
    logic [31:0]  b_mrdata = '0;
    logic [0:0]   b_mresp = '0;
    logic [3:0]   b_grant;
    logic         b_busy;
    logic         b_timeout;
    logic         b_dbg;

    mem_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
        .MRESP_WIDTH(1), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk_i(clk), .arst_ni(arst_n),
        .req_i(b_req), .req_addr_i(b_addr), .req_we_i(b_we),
        .req_wdata_i(b_wdata), .req_strb_i(b_strb),
        .req_ack_o(b_ack), .req_rdata_o(b_rdata), .req_resp_o(b_resp),
        .mreq_o(b_mreq), .maddr_o(b_maddr), .mwe_o(b_mwe),
        .mwdata_o(b_mwdata), .mstrb_o(b_mstrb),
        .mack_i(b_mack), .mrdata_i(b_mrdata), .mresp_i(b_mresp),
        .grant_o(b_grant), .busy_o(b_busy), .timeout_o(b_timeout),
        .dbg_state_o(b_dbg)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // A granted requester must keep req_i high until its ack.
    always @(negedge clk) begin
        if (arst_n && a_busy) check("a_req_held", 64'(a_grant & ~a_req), 64'd0);
        if (arst_n && b_busy) check("b_req_held", 64'(b_grant & ~b_req), 64'd0);
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [1:0] exp_g;

        // Reset state
        #2;
        check("rst_grant", 64'(a_grant), 64'd0);
        check("rst_mreq", 64'(a_mreq), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_dbg", 64'(a_dbg), 64'd0);
        check("rst_timeout", 64'(a_timeout), 64'd0);
        check("rst_ack", 64'(a_ack), 64'd0);
        check("rst_rdata", 64'(a_rdata), 64'd0);
        check("rst_resp", 64'(a_resp), 64'd0);
        check("rst_payload", 64'({a_maddr, a_mwe, a_mstrb}), 64'd0);
        check("rst_mwdata", 64'(a_mwdata), 64'd0);
        check("rst_b_outs", 64'({b_grant, b_mreq, b_busy, b_dbg, b_timeout, b_ack, b_resp}), 64'd0);
        check("rst_b_data", 64'({b_rdata, b_mwdata}), 64'd0);
        check("rst_b_pay", 64'({b_mwe, b_mstrb}), 64'd0);
        #20;
        arst_n = 1'b1;

        // Single requester write, ack on cycle 3
        next_cyc();
        a_req = 2'b01; a_addr[31:0] = 32'h10; a_we = 2'b01;
        a_wdata[31:0] = 32'hA5A5_A5A5; a_strb[3:0] = 4'hF;
        sample();
        check("single_c0_mreq", 64'(a_mreq), 64'd0);
        next_cyc(); sample();
        check("single_c1_mreq", 64'(a_mreq), 64'd1);
        check("single_c1_grant", 64'(a_grant), 64'b01);
        check("single_c1_dbg", 64'(a_dbg), 64'd1);
        check("single_maddr", 64'(a_maddr), 64'h10);
        check("single_mwe", 64'(a_mwe), 64'd1);
        check("single_mwdata", 64'(a_mwdata), 64'hA5A5_A5A5);
        check("single_mstrb", 64'(a_mstrb), 64'hF);
        check("single_c1_ack", 64'(a_ack), 64'd0);
        next_cyc(); sample();
        check("single_c2_mreq", 64'(a_mreq), 64'd1);
        next_cyc();
        a_mack = 1'b1;
        sample();
        check("single_c3_ack", 64'(a_ack), 64'b01);
        check("single_c3_mreq", 64'(a_mreq), 64'd1);
        next_cyc();
        a_mack = 1'b0; a_req = 2'b00;
        sample();
        check("single_c4_mreq", 64'(a_mreq), 64'd0);
        check("single_c4_ack", 64'(a_ack), 64'd0);

        // Read return from requester 1 (pointer is now 1)
        next_cyc();
        a_req = 2'b10; a_we = 2'b00; a_addr[63:32] = 32'h44;
        a_mrdata = 32'hDEAD_BEEF; a_mresp = 1'b0;
        sample();
        next_cyc(); sample();
        check("read_grant", 64'(a_grant), 64'b10);
        check("read_maddr", 64'(a_maddr), 64'h44);
        check("read_mwe", 64'(a_mwe), 64'd0);
        check("read_rdata_noack", 64'(a_rdata), 64'd0);
        next_cyc();
        a_mack = 1'b1;
        sample();
        check("read_ack", 64'(a_ack), 64'b10);
        check("read_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
        check("read_resp", 64'(a_resp), 64'd0);
        next_cyc();
        a_mack = 1'b0; a_req = 2'b00; a_mrdata = '0;
        sample();
        check("read_done_mreq", 64'(a_mreq), 64'd0);

        // Fairness: both held, pointer is 0
        next_cyc();
        a_req = 2'b11; a_addr = {32'h200, 32'h100};
        sample();
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
        for (int t = 0; t < 4; t++) begin
            next_cyc(); sample();
            exp_g = exp_q.pop_front();
            check("fair_mreq", 64'(a_mreq), 64'd1);
            check("fair_grant", 64'(a_grant), 64'(exp_g));
            check("fair_maddr", 64'(a_maddr), (exp_g == 2'b01) ? 64'h100 : 64'h200);
            next_cyc();
            a_mack = 1'b1;
            sample();
            check("fair_ack", 64'(a_ack), 64'(exp_g));
            next_cyc();
            a_mack = 1'b0;
            if (t == 3) a_req = 2'b00;
            sample();
            check("fair_idle_gap", 64'(a_mreq), 64'd0);
        end

        // Watchdog timeout: requester 0, no ack, pointer 0
        next_cyc();
        a_req = 2'b01; a_mrdata = 32'h1234_5678; a_mresp = 1'b0;
        sample();
        for (int c = 1; c <= 4; c++) begin
            next_cyc(); sample();
            check("to_mreq", 64'(a_mreq), 64'd1);
            if (c < 4) begin
                check("to_early_ack", 64'(a_ack), 64'd0);
                check("to_early_timeout", 64'(a_timeout), 64'd0);
            end else begin
                check("to_ack", 64'(a_ack), 64'b01);
                check("to_timeout", 64'(a_timeout), 64'd1);
                check("to_resp", 64'(a_resp), 64'd1);
                check("to_rdata", 64'(a_rdata), 64'd0);
            end
        end
        next_cyc();
        a_req = 2'b00; a_mack = 1'b1;
        sample();
        check("stray_ack", 64'(a_ack), 64'd0);
        check("stray_mreq", 64'(a_mreq), 64'd0);
        check("stray_timeout", 64'(a_timeout), 64'd0);
        check("stray_rdata", 64'(a_rdata), 64'd0);
        next_cyc();
        a_mack = 1'b0;
        sample();
        check("stray_busy", 64'(a_busy), 64'd0);

        // Tie: mack on the 4th BUSY cycle wins, requester 1 (pointer 1)
        next_cyc();
        a_req = 2'b10; a_mrdata = 32'hCAFE_F00D;
        sample();
        for (int c = 1; c <= 3; c++) begin
            next_cyc(); sample();
            check("tie_early_ack", 64'(a_ack), 64'd0);
        end
        next_cyc();
        a_mack = 1'b1;
        sample();
        check("tie_ack", 64'(a_ack), 64'b10);
        check("tie_timeout", 64'(a_timeout), 64'd0);
        check("tie_resp", 64'(a_resp), 64'd0);
        check("tie_rdata", 64'(a_rdata), 64'hCAFE_F00D);
        next_cyc();
        a_mack = 1'b0; a_req = 2'b00; a_mrdata = '0;
        sample();
        check("tie_done_mreq", 64'(a_mreq), 64'd0);

        // Reset mid-transaction with requester 1 (pointer 0)
        next_cyc();
        a_req = 2'b10;
        sample();
        next_cyc(); sample();
        check("rmid_grant_pre", 64'(a_grant), 64'b10);
        next_cyc();
        arst_n = 1'b0;
        #1;
        check("rmid_mreq", 64'(a_mreq), 64'd0);
        check("rmid_grant", 64'(a_grant), 64'd0);
        check("rmid_busy", 64'(a_busy), 64'd0);
        a_req = 2'b11;
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        next_cyc(); sample();
        check("rmid_after_grant", 64'(a_grant), 64'b01);
        next_cyc();
        a_mack = 1'b1;
        sample();
        check("rmid_after_ack", 64'(a_ack), 64'b01);
        next_cyc();
        a_mack = 1'b0; a_req = 2'b00;
        sample();
        check("rmid_done_mreq", 64'(a_mreq), 64'd0);

        // Wrap on the 4-port instance
        next_cyc();
        b_req = 4'b0100;
        b_addr[95:64] = 32'h300; b_addr[31:0] = 32'h1000;
        sample();
        next_cyc(); sample();
        check("wrap_g2", 64'(b_grant), 64'b0100);
        check("wrap_g2_maddr", 64'(b_maddr), 64'h300);
        next_cyc();
        b_mack = 1'b1;
        sample();
        check("wrap_g2_ack", 64'(b_ack), 64'b0100);
        next_cyc();
        b_mack = 1'b0; b_req = 4'b0101;
        sample();
        check("wrap_gap", 64'(b_mreq), 64'd0);
        next_cyc(); sample();
        check("wrap_g0", 64'(b_grant), 64'b0001);
        check("wrap_g0_maddr", 64'(b_maddr), 64'h1000);
        next_cyc();
        b_mack = 1'b1;
        sample();
        check("wrap_g0_ack", 64'(b_ack), 64'b0001);
        next_cyc();
        b_mack = 1'b0; b_req = 4'b0100;
        sample();
        next_cyc(); sample();
        check("wrap_g2_again", 64'(b_grant), 64'b0100);
        next_cyc();
        b_mack = 1'b1;
        sample();
        check("wrap_g2_again_ack", 64'(b_ack), 64'b0100);
        next_cyc();
        b_mack = 1'b0; b_req = 4'b0000;
        sample();
        check("wrap_done_mreq", 64'(b_mreq), 64'd0);

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
